// File: rtl/useq_irq.sv
// Parametrised two-phase micro-sequencer: accumulator core, register file, return stack and
// prioritised edge-triggered interrupts with per-line acknowledge.
module useq_irq #(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned NREGS       = 16,
    parameter int unsigned STACK_DEPTH = 4,
    parameter int unsigned N_IRQ       = 4,
    parameter int unsigned IRQ_BASE    = 'h08
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        mem_data,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] i_port,
    output logic [DATA_W-1:0] o_port,
    input  logic [N_IRQ-1:0]  irq,
    output logic [N_IRQ-1:0]  irq_ack,
    output logic              stk_err
);
    localparam int unsigned SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int unsigned IDX_W = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

    typedef enum logic {StFetch, StExec} state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] pc_q, epc_q;
    logic [DATA_W-1:0] a_q, o_port_q, ip_q;
    logic [DATA_W-1:0] regs_q [16];
    logic [ADDR_W-1:0] stack_q [2**SP_W];
    logic [SP_W-1:0]   sp_q;
    logic [7:0]        instr_q;
    logic [N_IRQ-1:0]  irq_ack_q, pending_q, mask_q, irq_s1_q, irq_s2_q;
    logic              stk_err_q, ie_q;

    // Interrupt selection: lowest pending, unmasked index wins.
    logic             irq_hit, take_irq;
    logic [IDX_W-1:0] irq_idx;
    logic [N_IRQ-1:0] irq_oh, pend_clr;

    always_comb begin
        irq_hit = 1'b0;
        irq_idx = '0;
        for (int k = N_IRQ - 1; k >= 0; k--) begin
            if (pending_q[k] && mask_q[k]) begin
                irq_hit = 1'b1;
                irq_idx = IDX_W'(k);
            end
        end
    end

    assign take_irq = (state_q == StFetch) && ie_q && irq_hit;
    assign irq_oh   = N_IRQ'(1) << irq_idx;
    assign pend_clr = take_irq ? irq_oh : '0;

    // Execute-phase decode.
    logic [3:0]        op, r;
    logic              reg_ok, reg_we, out_we, push, pop, err, mask_we, rti;
    logic [DATA_W-1:0] rdata, a_d;
    logic [ADDR_W-1:0] pc_inc, pc_d;

    always_comb begin
        op      = instr_q[7:4];
        r       = instr_q[3:0];
        reg_ok  = 32'(r) < NREGS;
        rdata   = reg_ok ? regs_q[r] : '0;
        pc_inc  = pc_q + ADDR_W'(1);
        a_d     = a_q;
        pc_d    = pc_inc;
        reg_we  = 1'b0;
        out_we  = 1'b0;
        push    = 1'b0;
        pop     = 1'b0;
        err     = 1'b0;
        mask_we = 1'b0;
        rti     = 1'b0;
        case (op)
            4'h0: a_d = rdata;
            4'h1: reg_we = reg_ok;
            4'h2: a_d = a_q + rdata;
            4'h3: a_d = a_q - rdata;
            4'h4: a_d = a_q & rdata;
            4'h5: a_d = a_q | rdata;
            4'h6: a_d = a_q ^ rdata;
            4'h7: a_d = {a_q[DATA_W-5:0], r};
            4'h8: pc_d = pc_q + ADDR_W'(r) + ADDR_W'(1);
            4'h9: if (a_q != '0) pc_d = pc_q - ADDR_W'(r) - ADDR_W'(1);
            4'hB: if (a_q == rdata) pc_d = pc_q + ADDR_W'(2);
            4'hA: begin
                case (r)
                    4'h0: a_d = a_q + DATA_W'(1);
                    4'h1: a_d = a_q - DATA_W'(1);
                    4'h2: a_d = a_q << 1;
                    4'h3: a_d = a_q >> 1;
                    4'h4: a_d = ~a_q;
                    4'h5: a_d = '0;
                    4'h6: out_we = 1'b1;
                    4'h7: a_d = ip_q;
                    4'h8: begin
                        if (sp_q == SP_W'(STACK_DEPTH)) begin
                            err = 1'b1;
                        end else begin
                            push = 1'b1;
                            pc_d = a_q[ADDR_W-1:0];
                        end
                    end
                    4'h9: begin
                        if (sp_q == '0) begin
                            err = 1'b1;
                        end else begin
                            pop  = 1'b1;
                            pc_d = stack_q[sp_q - SP_W'(1)];
                        end
                    end
                    4'hA: mask_we = 1'b1;
                    4'hB: begin
                        rti  = 1'b1;
                        pc_d = epc_q;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StFetch;
            pc_q      <= '0;
            epc_q     <= '0;
            a_q       <= '0;
            o_port_q  <= '0;
            ip_q      <= '0;
            sp_q      <= '0;
            instr_q   <= '0;
            irq_ack_q <= '0;
            pending_q <= '0;
            mask_q    <= '0;
            irq_s1_q  <= '0;
            irq_s2_q  <= '0;
            stk_err_q <= 1'b0;
            ie_q      <= 1'b1;
            for (int i = 0; i < 16; i++) regs_q[i] <= '0;
            for (int i = 0; i < 2**SP_W; i++) stack_q[i] <= '0;
        end else begin
            irq_s1_q  <= irq;
            irq_s2_q  <= irq_s1_q;
            ip_q      <= i_port;
            irq_ack_q <= '0;
            // A new edge outranks a same-cycle clear.
            pending_q <= (pending_q & ~pend_clr) | (irq_s1_q & ~irq_s2_q);
            case (state_q)
                StFetch: begin
                    if (take_irq) begin
                        epc_q     <= pc_q;
                        ie_q      <= 1'b0;
                        irq_ack_q <= irq_oh;
                        pc_q      <= ADDR_W'(IRQ_BASE) + ADDR_W'(irq_idx);
                    end else begin
                        instr_q <= mem_data;
                        state_q <= StExec;
                    end
                end
                StExec: begin
                    a_q     <= a_d;
                    pc_q    <= pc_d;
                    state_q <= StFetch;
                    if (reg_we) regs_q[r] <= a_q;
                    if (out_we) o_port_q <= a_q;
                    if (mask_we) mask_q <= a_q[N_IRQ-1:0];
                    if (rti) ie_q <= 1'b1;
                    if (err) stk_err_q <= 1'b1;
                    if (push) begin
                        stack_q[sp_q] <= pc_inc;
                        sp_q          <= sp_q + SP_W'(1);
                    end
                    if (pop) sp_q <= sp_q - SP_W'(1);
                end
                default: state_q <= StFetch;
            endcase
        end
    end

    assign mem_addr = pc_q;
    assign o_port   = o_port_q;
    assign irq_ack  = irq_ack_q;
    assign stk_err  = stk_err_q;

endmodule

// File: tb/tb_useq_irq.sv
// Bench for useq_irq: instruction-level reference model compared every cycle, plus directed
// programs with hand-computed expectations and randomized programs/interrupts.
module tb_useq_irq;
    localparam int DW = 16, AW = 8, NR = 12, SD = 2, NI = 4, IB = 'h08;
    localparam int DM = 'hFFFF, AM = 'hFF;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    mem_data;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] i_port = '0;
    logic [DW-1:0] o_port;
    logic [NI-1:0] irq = '0;
    logic [NI-1:0] irq_ack;
    logic          stk_err;
    logic [7:0]    rom [256];

    int n_chk = 0, n_pass = 0, n_fail = 0;

    useq_irq #(
        .DATA_W(DW), .ADDR_W(AW), .NREGS(NR), .STACK_DEPTH(SD), .N_IRQ(NI), .IRQ_BASE(IB)
    ) dut (
        .clk(clk), .rst(rst), .mem_data(mem_data), .mem_addr(mem_addr), .i_port(i_port),
        .o_port(o_port), .irq(irq), .irq_ack(irq_ack), .stk_err(stk_err)
    );

    assign mem_data = rom[mem_addr];
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Reference model: one instruction interpreter stepped per clock.
    int m_a, m_pc, m_instr, m_out, m_ack, m_pend, m_mask, m_epc, m_ip, m_irq1, m_irq2;
    int m_r [16];
    int m_stk [$];
    bit m_fetch, m_err, m_ie;

    function automatic int rd(input int r);
        return (r < NR) ? m_r[r] : 0;
    endfunction

    task automatic m_reset();
        m_a = 0; m_pc = 0; m_instr = 0; m_out = 0; m_ack = 0; m_pend = 0; m_mask = 0;
        m_epc = 0; m_ip = 0; m_irq1 = 0; m_irq2 = 0; m_fetch = 1; m_err = 0; m_ie = 1;
        for (int i = 0; i < 16; i++) m_r[i] = 0;
        m_stk.delete();
    endtask

    task automatic m_step();
        int edge_v, op, r, k, rv, nxt;
        edge_v = m_irq1 & ~m_irq2 & 'hF;
        m_ack = 0;
        if (m_fetch) begin
            if (m_ie && (m_pend & m_mask) != 0) begin
                k = 0;
                while ((((m_pend & m_mask) >> k) & 1) == 0) k++;
                m_epc = m_pc; m_ie = 0; m_pend &= ~(1 << k); m_ack = 1 << k;
                m_pc = (IB + k) & AM;
            end else begin
                m_instr = rom[m_pc];
                m_fetch = 0;
            end
        end else begin
            op = m_instr >> 4; r = m_instr & 15; rv = rd(r); nxt = m_pc + 1;
            case (op)
                0: m_a = rv;
                1: if (r < NR) m_r[r] = m_a;
                2: m_a = (m_a + rv) & DM;
                3: m_a = (m_a - rv) & DM;
                4: m_a = m_a & rv;
                5: m_a = m_a | rv;
                6: m_a = m_a ^ rv;
                7: m_a = ((m_a << 4) | r) & DM;
                8: nxt = m_pc + r + 1;
                9: if (m_a != 0) nxt = m_pc - r - 1;
                11: if (m_a == rv) nxt = m_pc + 2;
                10: case (r)
                    0: m_a = (m_a + 1) & DM;
                    1: m_a = (m_a - 1) & DM;
                    2: m_a = (m_a * 2) & DM;
                    3: m_a = m_a / 2;
                    4: m_a = DM - m_a;
                    5: m_a = 0;
                    6: m_out = m_a;
                    7: m_a = m_ip;
                    8: if (m_stk.size() == SD) m_err = 1;
                       else begin m_stk.push_back((m_pc + 1) & AM); nxt = m_a & AM; end
                    9: if (m_stk.size() == 0) m_err = 1; else nxt = m_stk.pop_back();
                    10: m_mask = m_a & 'hF;
                    11: begin nxt = m_epc; m_ie = 1; end
                    default: ;
                endcase
                default: ;
            endcase
            m_pc = nxt & AM;
            m_fetch = 1;
        end
        m_pend |= edge_v;
        m_ip = i_port; m_irq2 = m_irq1; m_irq1 = irq;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) m_reset();
        else m_step();
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("o_port", o_port, m_out);
            check("mem_addr", mem_addr, m_pc);
            check("irq_ack", irq_ack, m_ack);
            check("stk_err", stk_err, m_err);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; irq = '0; i_port = '0;
        @(posedge clk); @(posedge clk); @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic fill_nop();
        for (int i = 0; i < 256; i++) rom[i] = 8'hC0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cnt;
        logic [7:0] b;

        // Constant build-up and OUT.
        fill_nop();
        rom[0] = 8'h71; rom[1] = 8'h72; rom[2] = 8'h13; rom[3] = 8'hA5;
        rom[4] = 8'h23; rom[5] = 8'hA6;
        do_reset();
        check("rst o_port", o_port, 0);
        check("rst mem_addr", mem_addr, 0);
        check("rst irq_ack", irq_ack, 0);
        check("rst stk_err", stk_err, 0);
        cyc(11); check("const o_port early", o_port, 0);
        cyc(1);  check("const o_port", o_port, 'h12);

        // Countdown loop.
        fill_nop();
        rom[0] = 8'h73; rom[1] = 8'hA1; rom[2] = 8'h90; rom[3] = 8'hA0; rom[4] = 8'hA6;
        do_reset();
        cyc(14); check("jnz exit pc", mem_addr, 3);
        cyc(4);  check("jnz A after exit", o_port, 1);
        check("jnz pc after out", mem_addr, 5);

        // Calls, overflow, returns, then async reset mid-EXECUTE of a CALL.
        fill_nop();
        rom[0] = 8'h72; rom[1] = 8'h70; rom[2] = 8'hA8; rom[3] = 8'hA6;
        rom['h20] = 8'hA8; rom['h21] = 8'hA9;
        do_reset();
        cyc(9); check("call no err yet", stk_err, 0);
        cyc(1); check("call overflow err", stk_err, 1);
        check("call overflow pc", mem_addr, 'h21);
        cyc(6); check("ret o_port", o_port, 'h20);
        check("ret pc", mem_addr, 4);
        cnt = 0;
        while (mem_addr != 8'h20 && cnt < 200) begin cyc(1); cnt++; end
        check("reach call timeout", (cnt < 200) ? 1 : 0, 1);
        cyc(1);
        check("pre-reset err", stk_err, 1);
        rst = 1'b1; #1;
        check("async rst o_port", o_port, 0);
        check("async rst stk_err", stk_err, 0);
        check("async rst mem_addr", mem_addr, 0);
        check("async rst irq_ack", irq_ack, 0);
        @(posedge clk); @(negedge clk); rst = 1'b0;
        cyc(2); check("restart pc", mem_addr, 1);

        // Masked interrupt stays pending until SEI.
        fill_nop();
        rom[2] = 8'h71; rom[3] = 8'hAA; rom[8] = 8'hAB;
        do_reset();
        irq = 4'b0001; cyc(1); irq = '0;
        cyc(7); check("masked no ack", irq_ack, 0);
        check("masked pc", mem_addr, 4);
        cyc(1); check("sei ack", irq_ack, 1);
        check("sei vector", mem_addr, IB);
        cyc(1); check("ack one cycle", irq_ack, 0);
        cyc(1); check("rti return", mem_addr, 4);

        // Priority with simultaneous edges; second taken right after RTI.
        fill_nop();
        rom[0] = 8'h76; rom[1] = 8'hAA; rom[2] = 8'h90;
        rom[8] = 8'hAB; rom[9] = 8'hAB; rom['hA] = 8'hAB;
        do_reset();
        cyc(10);
        irq = 4'b0110; cyc(1); irq = '0;
        cnt = 0;
        while (irq_ack == '0 && cnt < 20) begin cyc(1); cnt++; end
        check("prio first ack", irq_ack, 4'b0010);
        check("prio first vector", mem_addr, IB + 1);
        cnt = 0;
        do begin cyc(1); cnt++; end while (irq_ack == '0 && cnt < 20);
        check("prio second ack", irq_ack, 4'b0100);
        check("prio second vector", mem_addr, IB + 2);
        check("prio second delay", cnt, 3);

        // Randomized programs with random interrupts and input port.
        for (int p = 0; p < 4; p++) begin
            for (int i = 0; i < 256; i++) begin
                case ($urandom_range(0, 3))
                    0: b = 8'hA6;
                    1: b = 8'hA0 | 8'($urandom_range(0, 15));
                    default: b = 8'($urandom);
                endcase
                rom[i] = b;
            end
            do_reset();
            for (int c = 0; c < 1500; c++) begin
                irq = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0;
                i_port = 16'($urandom);
                cyc(1);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
